time_setter: RTL and testbench

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/time_setter_pkg.sv | 73 +++++++
 rtl/time_setter_debouncer.sv | 68 ++++++
 rtl/time_setter.sv | 184 ++++++++++++++++++
 tb/tb_time_setter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_setter_pkg.sv
// ---------------------------------------------------------------------------
// time_setter_pkg
//
// Definitions shared by the time-setting front end and the countdown chain
// that consumes its digits.
//   - FSM state encodings (3-bit localparams, legacy-compatible)
//   - selected-digit codes driven on the sel output
//   - default debounce length and default maximum value of each digit
//   - digit / entry types and small helpers for digit arithmetic and decoding
// ---------------------------------------------------------------------------
package time_setter_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SET_MIN  = 3'd1;
  localparam logic [2:0] ST_SET_TENS = 3'd2;
  localparam logic [2:0] ST_SET_ONES = 3'd3;
  localparam logic [2:0] ST_LOAD     = 3'd4;

  // Selected-digit codes (0 means no digit is being edited)
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_TENS = 2'd2;
  localparam logic [1:0] SEL_ONES = 2'd3;

  // Default digit maxima: minutes 0-9, seconds 00-59
  localparam int DEF_MIN_MAX  = 9;
  localparam int DEF_TENS_MAX = 5;
  localparam int DEF_ONES_MAX = 9;

  // Default number of stable samples before a button level is accepted
  localparam int DEF_DEBOUNCE_CYCLES = 10;

  typedef logic [3:0] digit_t;

  // One complete time entry, as handed to the countdown chain
  typedef struct packed {
    digit_t minutes;
    digit_t tens;
    digit_t ones;
  } entry_t;

  // Increment a digit, wrapping to 0 once it has reached its maximum.
  // Using >= also pulls an out-of-range value back to 0.
  function automatic digit_t next_digit(input digit_t value, input digit_t max_value);
    if (value >= max_value) begin
      return '0;
    end
    return value + digit_t'(1);
  endfunction

  // Digit selection implied by an FSM state
  function automatic logic [1:0] sel_of_state(input logic [2:0] state);
    case (state)
      ST_SET_MIN:  return SEL_MIN;
      ST_SET_TENS: return SEL_TENS;
      ST_SET_ONES: return SEL_ONES;
      default:     return SEL_NONE;
    endcase
  endfunction

  // Bit of digit_blank that belongs to a selected digit
  // ([2]=minutes, [1]=tens, [0]=ones)
  function automatic logic [2:0] blank_mask(input logic [1:0] sel);
    case (sel)
      SEL_MIN:  return 3'b100;
      SEL_TENS: return 3'b010;
      SEL_ONES: return 3'b001;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/time_setter_debouncer.sv
// ---------------------------------------------------------------------------
// debouncer
//
// Conditions one raw, asynchronous, active-high push button.
//   - two-flop synchroniser
//   - stable counter: the accepted level follows the synchronised input only
//     after DEBOUNCE_CYCLES consecutive samples that differ from it
//   - one-cycle press pulse on the accepted level's 0->1 transition
//     (a release produces no pulse)
//
// Ports
//   clk    in   sampling clock
//   reset  in   asynchronous, active-low reset
//   raw    in   raw button input
//   press  out  registered one-cycle press pulse
// ---------------------------------------------------------------------------
module debouncer
  import time_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          level;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // The counter tracks how many consecutive samples have disagreed with the
  // accepted level. Any agreeing sample restarts the count, so bouncing
  // shorter than DEBOUNCE_CYCLES is never accepted. The press pulse is raised
  // on the same edge that the level flips to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else if (sync_b == level) begin
      stable_cnt <= '0;
      press      <= 1'b0;
    end else if (stable_cnt == CNT_LAST) begin
      level      <= sync_b;
      stable_cnt <= '0;
      press      <= sync_b;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
      press      <= 1'b0;
    end
  end

endmodule

// File: rtl/time_setter.sv
// ---------------------------------------------------------------------------
// time_setter
//
// Front panel for entering a M:SS countdown time with two buttons. A mode
// press (while the timer is not busy) starts editing at the minutes digit;
// further mode presses step minutes -> tens -> ones -> load. Inc presses
// bump the selected digit, wrapping at its maximum. Leaving the ones digit
// issues a one-cycle load strobe for the countdown chain and returns to
// idle. The entered digits persist between entries.
//
// Optional feature (macro BLINK_EN):
//   defined   - the selected digit's digit_blank bit toggles every
//               BLINK_CYCLES clocks while editing; the blink phase restarts
//               (digit visible) whenever the selection changes
//   undefined - digit_blank is constant 0 and no blink counter is built
//
// Ports
//   clk          in   display-rate clock for all logic
//   reset        in   asynchronous, active-low reset
//   btn_mode     in   raw mode button (active-high)
//   btn_inc      in   raw increment button (active-high)
//   timer_busy   in   countdown chain is running
//   minutes      out  entered minutes digit
//   tens         out  entered tens-of-seconds digit
//   ones         out  entered ones-of-seconds digit
//   load         out  one-cycle strobe, counter chain loads the digits
//   editing      out  high in any SET_* state
//   sel          out  selected digit: 0 none, 1 minutes, 2 tens, 3 ones
//   digit_blank  out  blank mask [2]=minutes [1]=tens [0]=ones
// ---------------------------------------------------------------------------
module time_setter
  import time_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_MAX         = DEF_MIN_MAX,
  parameter int TENS_MAX        = DEF_TENS_MAX,
  parameter int ONES_MAX        = DEF_ONES_MAX
`ifdef BLINK_EN
  ,
  parameter int BLINK_CYCLES    = 125
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       timer_busy,
  output logic [3:0] minutes,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       load,
  output logic       editing,
  output logic [1:0] sel,
  output logic [2:0] digit_blank
);

  localparam digit_t MIN_MAX_D  = digit_t'(MIN_MAX);
  localparam digit_t TENS_MAX_D = digit_t'(TENS_MAX);
  localparam digit_t ONES_MAX_D = digit_t'(ONES_MAX);

  logic       mode_press;
  logic       inc_press;
  logic [2:0] state;
  logic [2:0] state_next;
  entry_t     entry;
  entry_t     entry_next;
  logic [1:0] sel_next;

  debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_mode_debouncer (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mode),
    .press (mode_press)
  );

  debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_inc_debouncer (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_inc),
    .press (inc_press)
  );

  // Next-state and digit-update logic. Mode is checked before inc in every
  // edit state, so a simultaneous inc press is simply dropped. timer_busy
  // only gates entry from IDLE; once editing, it has no effect.
  always_comb begin
    state_next = state;
    entry_next = entry;
    case (state)
      ST_IDLE: begin
        if (mode_press && !timer_busy) begin
          state_next = ST_SET_MIN;
        end
      end
      ST_SET_MIN: begin
        if (mode_press) begin
          state_next = ST_SET_TENS;
        end else if (inc_press) begin
          entry_next.minutes = next_digit(entry.minutes, MIN_MAX_D);
        end
      end
      ST_SET_TENS: begin
        if (mode_press) begin
          state_next = ST_SET_ONES;
        end else if (inc_press) begin
          entry_next.tens = next_digit(entry.tens, TENS_MAX_D);
        end
      end
      ST_SET_ONES: begin
        if (mode_press) begin
          state_next = ST_LOAD;
        end else if (inc_press) begin
          entry_next.ones = next_digit(entry.ones, ONES_MAX_D);
        end
      end
      ST_LOAD: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign sel_next = sel_of_state(state_next);

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state itself; load is therefore high exactly during the
  // single LOAD cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      entry   <= '0;
      load    <= 1'b0;
      sel     <= SEL_NONE;
      editing <= 1'b0;
    end else begin
      state   <= state_next;
      entry   <= entry_next;
      load    <= (state_next == ST_LOAD);
      sel     <= sel_next;
      editing <= (sel_next != SEL_NONE);
    end
  end

  assign minutes = entry.minutes;
  assign tens    = entry.tens;
  assign ones    = entry.ones;

`ifdef BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt;
  logic [2:0]    blank_q;

  // A change of selection (or leaving edit mode) restarts the phase with the
  // digit visible. While the selection is stable, the selected bit toggles
  // after every BLINK_CYCLES clocks; the other bits stay 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blank_q   <= 3'b000;
    end else if ((sel_next != sel) || (sel_next == SEL_NONE)) begin
      blink_cnt <= '0;
      blank_q   <= 3'b000;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blank_q   <= blank_q ^ blank_mask(sel_next);
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = 3'b000;
`endif

endmodule

// File: tb/tb_time_setter.sv
// ---------------------------------------------------------------------------
// tb_time_setter
//
// Directed bench for time_setter. Expected digit values are pushed into
// queues before each button press; a monitor pops and compares whenever the
// digits change or a load strobe appears. State-level outputs are checked
// directly after each press.
// ---------------------------------------------------------------------------
module tb_time_setter;

  localparam int DB  = 10;
  localparam int GAP = DB + 6;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
  } triple_t;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       btn_mode   = 1'b0;
  logic       btn_inc    = 1'b0;
  logic       timer_busy = 1'b0;
  logic [3:0] minutes;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       load;
  logic       editing;
  logic [1:0] sel;
  logic [2:0] digit_blank;

  triple_t digit_q[$];
  triple_t load_q[$];
  triple_t prev_digits = '0;
  int      total       = 0;
  int      bad         = 0;
  int      loads_seen  = 0;

  time_setter #(
    .DEBOUNCE_CYCLES (DB),
    .MIN_MAX         (9),
    .TENS_MAX        (5),
    .ONES_MAX        (9)
`ifdef BLINK_EN
    ,
    .BLINK_CYCLES    (4)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .timer_busy  (timer_busy),
    .minutes     (minutes),
    .tens        (tens),
    .ones        (ones),
    .load        (load),
    .editing     (editing),
    .sel         (sel),
    .digit_blank (digit_blank)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  function automatic triple_t t3(input int m, input int t, input int o);
    triple_t r;
    r.m = 4'(m);
    r.t = 4'(t);
    r.o = 4'(o);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Hold the chosen buttons long enough to be accepted and acted on, then
  // release and let the debouncers settle back to 0.
  task automatic applyStimulus(input logic mode, input logic inc);
    @(negedge clk);
    btn_mode = mode;
    btn_inc  = inc;
    repeat (GAP) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  // Monitor: on every falling edge, a load strobe pops the load queue and any
  // change of the digit outputs pops the digit queue. Reset clears the
  // reference copy instead of consuming an expectation.
  always @(negedge clk) begin
    triple_t cur;
    cur = {minutes, tens, ones};
    if (!reset) begin
      prev_digits = cur;
    end else begin
      if (load) begin
        loads_seen++;
        if (load_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_load: got load=1 digits %h expected no load", cur);
        end else begin
          checkOutput("load_digits", 32'(cur), 32'(load_q.pop_front()));
        end
      end
      if (cur != prev_digits) begin
        if (digit_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_digit_change: got %h expected %h", cur, prev_digits);
        end else begin
          checkOutput("digit_step", 32'(cur), 32'(digit_q.pop_front()));
        end
        prev_digits = cur;
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_minutes", 32'(minutes), 0);
    checkOutput("rst_tens", 32'(tens), 0);
    checkOutput("rst_ones", 32'(ones), 0);
    checkOutput("rst_load", 32'(load), 0);
    checkOutput("rst_editing", 32'(editing), 0);
    checkOutput("rst_sel", 32'(sel), 0);
    checkOutput("rst_blank", 32'(digit_blank), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_sel", 32'(sel), 0);

    // Full entry 3:02 (six tens presses walk 1..5 and wrap to 0)
    applyStimulus(1'b1, 1'b0);
    checkOutput("set_min_sel", 32'(sel), 1);
    checkOutput("set_min_editing", 32'(editing), 1);
`ifndef BLINK_EN
    repeat (8) begin
      @(negedge clk);
      checkOutput("blank_off", 32'(digit_blank), 0);
    end
`else
    begin : blink_check
      logic [2:0] v;
      int waited;
      waited = 0;
      v = digit_blank;
      while (digit_blank == v && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("blink_seen", 32'(waited < 20), 1);
      v = digit_blank;
      repeat (3) begin
        @(negedge clk);
        checkOutput("blink_hold", 32'(digit_blank), 32'(v));
      end
      @(negedge clk);
      checkOutput("blink_toggle", 32'(digit_blank), 32'(v ^ 3'b100));
    end
`endif
    for (int i = 1; i <= 3; i++) begin
      digit_q.push_back(t3(i, 0, 0));
      applyStimulus(1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("set_tens_sel", 32'(sel), 2);
    for (int i = 1; i <= 6; i++) begin
      digit_q.push_back(t3(3, i % 6, 0));
      applyStimulus(1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("set_ones_sel", 32'(sel), 3);
    for (int i = 1; i <= 2; i++) begin
      digit_q.push_back(t3(3, 0, i));
      applyStimulus(1'b0, 1'b1);
    end
    load_q.push_back(t3(3, 0, 2));
    applyStimulus(1'b1, 1'b0);
    checkOutput("after_load_sel", 32'(sel), 0);
    checkOutput("after_load_editing", 32'(editing), 0);
    checkOutput("after_load_strobe", 32'(load), 0);
    checkOutput("loads_after_first", 32'(loads_seen), 1);

    // Inc in IDLE is ignored and digits are retained after load
    applyStimulus(1'b0, 1'b1);
    checkOutput("idle_inc_minutes", 32'(minutes), 3);
    checkOutput("idle_inc_ones", 32'(ones), 2);

    // Mode while busy is ignored
    timer_busy = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("busy_sel", 32'(sel), 0);
    checkOutput("busy_editing", 32'(editing), 0);
    timer_busy = 1'b0;

    // Simultaneous mode and inc: mode wins, minutes untouched
    applyStimulus(1'b1, 1'b0);
    checkOutput("reenter_sel", 32'(sel), 1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("simul_sel", 32'(sel), 2);
    checkOutput("simul_minutes", 32'(minutes), 3);

    // Busy rising while editing does not abort, inc still works
    timer_busy = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("busy_edit_sel", 32'(sel), 2);
    checkOutput("busy_edit_editing", 32'(editing), 1);
    digit_q.push_back(t3(3, 1, 2));
    applyStimulus(1'b0, 1'b1);
    checkOutput("busy_edit_tens", 32'(tens), 1);
    timer_busy = 1'b0;

    // Bouncing inc (3-cycle runs for 30 cycles) then stable high: one step
    digit_q.push_back(t3(3, 2, 2));
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      btn_inc = ~btn_inc;
      repeat (3) @(negedge clk);
    end
    btn_inc = 1'b1;
    repeat (GAP) @(negedge clk);
    checkOutput("bounce_tens", 32'(tens), 2);
    btn_inc = 1'b0;
    repeat (GAP) @(negedge clk);

    // Asynchronous reset in the middle of SET_TENS
    checkOutput("pre_reset_sel", 32'(sel), 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_rst_minutes", 32'(minutes), 0);
    checkOutput("async_rst_tens", 32'(tens), 0);
    checkOutput("async_rst_ones", 32'(ones), 0);
    checkOutput("async_rst_sel", 32'(sel), 0);
    checkOutput("async_rst_editing", 32'(editing), 0);
    checkOutput("async_rst_load", 32'(load), 0);
    checkOutput("async_rst_blank", 32'(digit_blank), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_rst_enter_sel", 32'(sel), 1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_rst_ones_sel", 32'(sel), 3);
    load_q.push_back(t3(0, 0, 0));
    applyStimulus(1'b1, 1'b0);
    checkOutput("post_rst_idle_sel", 32'(sel), 0);
    checkOutput("loads_total", 32'(loads_seen), 2);

    checkOutput("digit_queue_left", 32'(digit_q.size()), 0);
    checkOutput("load_queue_left", 32'(load_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
